// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register.
// Carries the decoded instruction from ID into EX. It can also insert a NOP
// bubble, hold the current contents, or flush them, as the control unit's
// stall vector and the flush line direct. It also counts bubbles inserted
// since reset, using a saturating counter.
module id_ex_pipe #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [RADDR_W-1:0]  id_wd,
    input  logic                id_wreg,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_inst,
    input  logic [DATA_W-1:0]   id_link_addr,
    input  logic                id_is_in_delayslot,
    input  logic                id_next_in_delayslot,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [RADDR_W-1:0]  ex_wd,
    output logic                ex_wreg,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_inst,
    output logic [DATA_W-1:0]   ex_link_addr,
    output logic                ex_is_in_delayslot,
    output logic                ex_valid,
    output logic                is_in_delayslot_o,
    output logic [CNT_W-1:0]    bubble_cnt
);

    // Saturating increment: the bubble counter parks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Only the ID (bit 2) and EX (bit 3) stall bits matter here. The other
    // bits are folded into a deliberately unused signal.
    logic unused_stall_bits;
    assign unused_stall_bits = &{1'b0, stall[5:4], stall[1:0]};

    // ID is stalled but EX is free: EX gets a NOP.
    // If ID is not stalled, the block advances. This includes the
    // stall[2]=0 / stall[3]=1 combination, which control should never produce.
    logic bubble;
    logic advance;
    assign bubble  = stall[2] & ~stall[3];
    assign advance = ~stall[2];

    logic [DATA_W-1:0]   reg1_p1;
    logic [DATA_W-1:0]   reg2_p1;
    logic [RADDR_W-1:0]  wd_p1;
    logic                wreg_p1;
    logic [ALUOP_W-1:0]  aluop_p1;
    logic [ALUSEL_W-1:0] alusel_p1;
    logic [DATA_W-1:0]   inst_p1;
    logic [DATA_W-1:0]   link_addr_p1;
    logic                is_dslot_p1;
    logic                vld_p1;
    logic                next_dslot_p1;
    logic [CNT_W-1:0]    bubble_cnt_p1;

    // ---- ID -> EX boundary ----
    // Instruction fields are zeroed (NOP) on reset, flush or bubble, loaded on
    // advance, and otherwise held.
    always_ff @(posedge clk) begin
        if (rst || flush || bubble) begin
            reg1_p1      <= '0;
            reg2_p1      <= '0;
            wd_p1        <= '0;
            wreg_p1      <= 1'b0;
            aluop_p1     <= '0;
            alusel_p1    <= '0;
            inst_p1      <= '0;
            link_addr_p1 <= '0;
            is_dslot_p1  <= 1'b0;
        end else if (advance) begin
            reg1_p1      <= id_reg1;
            reg2_p1      <= id_reg2;
            wd_p1        <= id_wd;
            wreg_p1      <= id_wreg;
            aluop_p1     <= id_aluop;
            alusel_p1    <= id_alusel;
            inst_p1      <= id_inst;
            link_addr_p1 <= id_link_addr;
            is_dslot_p1  <= id_is_in_delayslot;
        end
    end

    // The valid flag follows the same rules as the fields: a bubble or a
    // flush leaves EX empty.
    always_ff @(posedge clk) begin
        if (rst || flush || bubble) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= 1'b1;
        end
    end

    // The delay-slot feedback to ID survives a bubble. Only reset or flush
    // clears it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            next_dslot_p1 <= 1'b0;
        end else if (advance) begin
            next_dslot_p1 <= id_next_in_delayslot;
        end
    end

    // Count inserted bubbles. A flush outranks the bubble, so it does not
    // count as one.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_p1 <= '0;
        end else if (!flush && bubble) begin
            bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end
    end

    assign ex_reg1            = reg1_p1;
    assign ex_reg2            = reg2_p1;
    assign ex_wd              = wd_p1;
    assign ex_wreg            = wreg_p1;
    assign ex_aluop           = aluop_p1;
    assign ex_alusel          = alusel_p1;
    assign ex_inst            = inst_p1;
    assign ex_link_addr       = link_addr_p1;
    assign ex_is_in_delayslot = is_dslot_p1;
    assign ex_valid           = vld_p1;
    assign is_in_delayslot_o  = next_dslot_p1;
    assign bubble_cnt         = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Testbench for id_ex_pipe.
// It runs a vector table through a scoreboard queue. It then runs a few
// hand-written multi-cycle sequences, and a second instance with a 2-bit
// bubble counter to exercise saturation.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] id_reg1, id_reg2, id_inst, id_link_addr;
    logic [4:0]  id_wd;
    logic        id_wreg;
    logic [7:0]  id_aluop;
    logic [2:0]  id_alusel;
    logic        id_is_in_delayslot, id_next_in_delayslot;

    logic [31:0] ex_reg1, ex_reg2, ex_inst, ex_link_addr;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic        ex_is_in_delayslot, ex_valid, is_in_delayslot_o;
    logic [15:0] bubble_cnt;

    logic [31:0] unused_s_reg1, unused_s_reg2, unused_s_inst, unused_s_link;
    logic [4:0]  unused_s_wd;
    logic        unused_s_wreg;
    logic [7:0]  unused_s_aluop;
    logic [2:0]  unused_s_alusel;
    logic        unused_s_isd, unused_s_valid, unused_s_dso;
    logic [1:0]  sat_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
        .id_aluop(id_aluop), .id_alusel(id_alusel), .id_inst(id_inst),
        .id_link_addr(id_link_addr), .id_is_in_delayslot(id_is_in_delayslot),
        .id_next_in_delayslot(id_next_in_delayslot),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_inst(ex_inst),
        .ex_link_addr(ex_link_addr), .ex_is_in_delayslot(ex_is_in_delayslot),
        .ex_valid(ex_valid), .is_in_delayslot_o(is_in_delayslot_o),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
        .id_aluop(id_aluop), .id_alusel(id_alusel), .id_inst(id_inst),
        .id_link_addr(id_link_addr), .id_is_in_delayslot(id_is_in_delayslot),
        .id_next_in_delayslot(id_next_in_delayslot),
        .ex_reg1(unused_s_reg1), .ex_reg2(unused_s_reg2), .ex_wd(unused_s_wd),
        .ex_wreg(unused_s_wreg), .ex_aluop(unused_s_aluop), .ex_alusel(unused_s_alusel),
        .ex_inst(unused_s_inst), .ex_link_addr(unused_s_link),
        .ex_is_in_delayslot(unused_s_isd), .ex_valid(unused_s_valid),
        .is_in_delayslot_o(unused_s_dso), .bubble_cnt(sat_cnt)
    );

    // Instruction payload derived from a 32-bit tag.
    typedef struct packed {
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] inst;
        logic [31:0] link;
        logic        isd;
    } pay_t;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [5:0]  stall;
        logic [31:0] tag;
        logic        nxd;
        logic        e_zero;
        logic [31:0] e_tag;
        logic        e_valid;
        logic        e_dso;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic        zero;
        logic [31:0] tag;
        logic        valid;
        logic        dso;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[19];

    localparam logic [31:0] TA = 32'h0013_2A47;
    localparam logic [31:0] TB = 32'h0025_3C19;
    localparam logic [31:0] TC = 32'h0046_7E0B;
    localparam logic [31:0] TD = 32'h0037_4F15;
    localparam logic [31:0] TE = 32'h0051_6D1E;

    function automatic pay_t payload(input logic [31:0] tag);
        pay_t p;
        p.reg1   = tag;
        p.reg2   = tag ^ 32'hA5A5_5A5A;
        p.wd     = tag[4:0];
        p.wreg   = 1'b1;
        p.aluop  = tag[15:8];
        p.alusel = tag[18:16];
        p.inst   = {tag[15:0], tag[31:16]};
        p.link   = tag + 32'd8;
        p.isd    = tag[20];
        return p;
    endfunction

    task automatic drive_payload(input logic [31:0] tag);
        pay_t p;
        p = payload(tag);
        id_reg1 = p.reg1; id_reg2 = p.reg2; id_wd = p.wd; id_wreg = p.wreg;
        id_aluop = p.aluop; id_alusel = p.alusel; id_inst = p.inst;
        id_link_addr = p.link; id_is_in_delayslot = p.isd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string nm, input exp_t e);
        pay_t p;
        p = e.zero ? '0 : payload(e.tag);
        check({nm, ".reg1"},   ex_reg1, p.reg1);
        check({nm, ".reg2"},   ex_reg2, p.reg2);
        check({nm, ".wd"},     32'(ex_wd), 32'(p.wd));
        check({nm, ".wreg"},   32'(ex_wreg), 32'(p.wreg));
        check({nm, ".aluop"},  32'(ex_aluop), 32'(p.aluop));
        check({nm, ".alusel"}, 32'(ex_alusel), 32'(p.alusel));
        check({nm, ".inst"},   ex_inst, p.inst);
        check({nm, ".link"},   ex_link_addr, p.link);
        check({nm, ".isd"},    32'(ex_is_in_delayslot), 32'(p.isd));
        check({nm, ".valid"},  32'(ex_valid), 32'(e.valid));
        check({nm, ".dso"},    32'(is_in_delayslot_o), 32'(e.dso));
        check({nm, ".cnt"},    32'(bubble_cnt), 32'(e.cnt));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        rst = v.rst; flush = v.flush; stall = v.stall;
        drive_payload(v.tag);
        id_next_in_delayslot = v.nxd;
        e.zero = v.e_zero; e.tag = v.e_tag; e.valid = v.e_valid;
        e.dso = v.e_dso; e.cnt = v.e_cnt;
        sb.push_back(e);
        tick();
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL vec%0d.scoreboard: got empty queue expected entry", idx);
        end else begin
            e = sb.pop_front();
            compare_all($sformatf("vec%0d", idx), e);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //                rst   flush stall       tag  nxd   zero  etag   vld   dso   cnt
        vecs[0]  = '{1'b1, 1'b0, 6'b000000, TA, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 6'b000000, TA, 1'b0, 1'b0, TA,    1'b1, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 6'b000000, TB, 1'b1, 1'b0, TB,    1'b1, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 6'b000100, TC, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 16'd1};
        vecs[4]  = '{1'b0, 1'b0, 6'b000000, TC, 1'b0, 1'b0, TC,    1'b1, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 1'b0, 6'b001100, TD, 1'b1, 1'b0, TC,    1'b1, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 1'b0, 6'b001100, TE, 1'b1, 1'b0, TC,    1'b1, 1'b0, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 6'b110011, TD, 1'b1, 1'b0, TD,    1'b1, 1'b1, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 6'b001000, TE, 1'b0, 1'b0, TE,    1'b1, 1'b0, 16'd1};
        vecs[9]  = '{1'b0, 1'b0, 6'b111111, TA, 1'b1, 1'b0, TE,    1'b1, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 1'b0, 6'b110111, TB, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 16'd2};
        vecs[11] = '{1'b0, 1'b0, 6'b000000, TA, 1'b1, 1'b0, TA,    1'b1, 1'b1, 16'd2};
        vecs[12] = '{1'b0, 1'b1, 6'b001100, TB, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 16'd2};
        vecs[13] = '{1'b0, 1'b0, 6'b000000, TB, 1'b0, 1'b0, TB,    1'b1, 1'b0, 16'd2};
        vecs[14] = '{1'b0, 1'b1, 6'b000100, TC, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 16'd2};
        vecs[15] = '{1'b0, 1'b0, 6'b000000, TC, 1'b1, 1'b0, TC,    1'b1, 1'b1, 16'd2};
        vecs[16] = '{1'b0, 1'b0, 6'b001100, TD, 1'b0, 1'b0, TC,    1'b1, 1'b1, 16'd2};
        vecs[17] = '{1'b1, 1'b1, 6'b001100, TD, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 16'd0};
        vecs[18] = '{1'b0, 1'b0, 6'b000000, TD, 1'b0, 1'b0, TD,    1'b1, 1'b0, 16'd0};

        rst = 1'b1; flush = 1'b0; stall = '0;
        drive_payload(32'h0);
        id_next_in_delayslot = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 19; i++) begin
            run_vec(i, vecs[i]);
        end

        // Directed advance with literal field values.
        rst = 1'b1; stall = '0; flush = 1'b0;
        tick();
        rst = 1'b0;
        id_reg1 = 32'h1234_5678; id_reg2 = '0; id_wd = 5'd7; id_wreg = 1'b1;
        id_aluop = 8'h25; id_alusel = '0; id_inst = '0; id_link_addr = '0;
        id_is_in_delayslot = 1'b0; id_next_in_delayslot = 1'b0;
        tick();
        check("adv.reg1",  ex_reg1, 32'h1234_5678);
        check("adv.wd",    32'(ex_wd), 32'd7);
        check("adv.wreg",  32'(ex_wreg), 32'd1);
        check("adv.aluop", 32'(ex_aluop), 32'h25);
        check("adv.valid", 32'(ex_valid), 32'd1);

        // Hold for three cycles while ID keeps changing.
        id_reg2 = 32'hDEAD_BEEF;
        tick();
        check("hold.load", ex_reg2, 32'hDEAD_BEEF);
        stall = 6'b001100;
        for (int k = 0; k < 3; k++) begin
            id_reg2 = 32'h0000_1000 + 32'(k);
            tick();
            check($sformatf("hold%0d.reg2", k), ex_reg2, 32'hDEAD_BEEF);
            check($sformatf("hold%0d.cnt", k), 32'(bubble_cnt), 32'd0);
            check($sformatf("hold%0d.valid", k), 32'(ex_valid), 32'd1);
        end

        // Saturation of the 2-bit counter over five bubbles, then reset.
        rst = 1'b1; stall = '0;
        tick();
        rst = 1'b0; stall = 6'b000100;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("sat%0d.cnt2", k), 32'(sat_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
            check($sformatf("sat%0d.cnt16", k), 32'(bubble_cnt), 32'(k + 1));
        end
        rst = 1'b1;
        tick();
        check("sat.rst.cnt2",  32'(sat_cnt), 32'd0);
        check("sat.rst.cnt16", 32'(bubble_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
